// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants for the GPIO pad controller.
//   GPIO_DIR_IN / GPIO_DIR_OUT     : encoding of a dir_i bit
//   GPIO_IRQ_LEVEL / GPIO_IRQ_EDGE : encoding of an irq_type_i bit
//   GPIO_NUM_DEF                   : default pin count of the bank
package gpio_pkg;

  localparam logic GPIO_DIR_IN    = 1'b0;
  localparam logic GPIO_DIR_OUT   = 1'b1;

  localparam logic GPIO_IRQ_LEVEL = 1'b0;
  localparam logic GPIO_IRQ_EDGE  = 1'b1;

  localparam int   GPIO_NUM_DEF   = 8;

endpackage : gpio_pkg

// File: rtl/gpio_deb.sv
// gpio_deb: single-pin input path. Two-flop synchronizer, debouncer with a
// programmable threshold, and an edge detector on the debounced value.
// Ports:
//   clk_i, rst_n_i : core clock, asynchronous active-low reset
//   deb_val_i      : debounce threshold N (0 = bypass)
//   pad_c_i        : raw pad input (asynchronous)
//   stb_o          : debounced stable value
//   rise_o, fall_o : one-cycle strobes when stb_o has just changed
module gpio_deb #(
  parameter int DEB_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [DEB_WIDTH-1:0] deb_val_i,
  input  logic                 pad_c_i,
  output logic                 stb_o,
  output logic                 rise_o,
  output logic                 fall_o
);

  logic                 s1_q, s2_q;
  logic                 stb_q, stb_d;
  logic                 stb_dly_q;
  logic [DEB_WIDTH-1:0] cnt_q, cnt_d;

  // The new level must be seen on s2 for N+1 consecutive compares before it
  // is accepted. The compare is >= so that lowering the threshold while a
  // count is running above it still lets the count terminate.
  always_comb begin
    stb_d = stb_q;
    cnt_d = cnt_q;
    if (s2_q == stb_q) begin
      cnt_d = '0;
    end else if (cnt_q >= deb_val_i) begin
      stb_d = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DEB_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      stb_q     <= 1'b0;
      stb_dly_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= pad_c_i;
      s2_q      <= s1_q;
      stb_q     <= stb_d;
      stb_dly_q <= stb_q;
      cnt_q     <= cnt_d;
    end
  end

  // stb and its delayed copy share a reset value, so no edge is reported
  // right after reset is released.
  assign stb_o  = stb_q;
  assign rise_o = stb_q & ~stb_dly_q;
  assign fall_o = ~stb_q & stb_dly_q;

endmodule : gpio_deb

// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: core-side controller for a bank of tri-state pull pads.
// Registers output data / output enable / pull enable toward the pads,
// returns each pad input through a synchronizer + debouncer, and raises
// per-pin edge- or level-triggered interrupts.
// Ports:
//   clk_i, rst_n_i  : core clock, asynchronous active-low reset
//   dir_i           : 1 = output, 0 = input
//   out_i           : output data
//   pull_en_i       : 1 = enable pad pull
//   deb_val_i       : shared debounce threshold (0 = bypass)
//   irq_en_i        : per-pin interrupt enable
//   irq_type_i      : 1 = edge, 0 = level
//   irq_pol_i       : 1 = rising/high, 0 = falling/low
//   irq_clr_i       : write-1-to-clear pulse for pending bits
//   pad_i_o         : pad output data
//   pad_oen_o       : pad output enable, active low (1 = hi-Z)
//   pad_ren_o       : pad pull enable, active low
//   pad_c_i         : pad input
//   in_o            : debounced input value (valid in output mode too)
//   irq_pend_o      : pending interrupt bits
//   irq_o           : OR of all pending bits
module gpio_pad_ctrl
  import gpio_pkg::*;
#(
  parameter int GPIO_NUM  = GPIO_NUM_DEF,
  parameter int DEB_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [GPIO_NUM-1:0]  dir_i,
  input  logic [GPIO_NUM-1:0]  out_i,
  input  logic [GPIO_NUM-1:0]  pull_en_i,
  input  logic [DEB_WIDTH-1:0] deb_val_i,
  input  logic [GPIO_NUM-1:0]  irq_en_i,
  input  logic [GPIO_NUM-1:0]  irq_type_i,
  input  logic [GPIO_NUM-1:0]  irq_pol_i,
  input  logic [GPIO_NUM-1:0]  irq_clr_i,
  output logic [GPIO_NUM-1:0]  pad_i_o,
  output logic [GPIO_NUM-1:0]  pad_oen_o,
  output logic [GPIO_NUM-1:0]  pad_ren_o,
  input  logic [GPIO_NUM-1:0]  pad_c_i,
  output logic [GPIO_NUM-1:0]  in_o,
  output logic [GPIO_NUM-1:0]  irq_pend_o,
  output logic                 irq_o
);

  logic [GPIO_NUM-1:0] pad_i_q,   pad_i_d;
  logic [GPIO_NUM-1:0] pad_oen_q, pad_oen_d;
  logic [GPIO_NUM-1:0] pad_ren_q, pad_ren_d;
  logic [GPIO_NUM-1:0] pend_q,    pend_d;

  logic [GPIO_NUM-1:0] stb;
  logic [GPIO_NUM-1:0] rise;
  logic [GPIO_NUM-1:0] fall;
  logic [GPIO_NUM-1:0] irq_evt;

  // Output path: pad enables are active low.
  always_comb begin
    pad_i_d   = out_i;
    pad_oen_d = ~dir_i;
    pad_ren_d = ~pull_en_i;
  end

  for (genvar g = 0; g < GPIO_NUM; g++) begin : g_pin
    gpio_deb #(
      .DEB_WIDTH (DEB_WIDTH)
    ) u_deb (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .deb_val_i (deb_val_i),
      .pad_c_i   (pad_c_i[g]),
      .stb_o     (stb[g]),
      .rise_o    (rise[g]),
      .fall_o    (fall[g])
    );
  end

  // Level mode fires every cycle the level matches, so a clear while the
  // level persists is immediately overridden by a fresh set.
  always_comb begin
    irq_evt = '0;
    for (int i = 0; i < GPIO_NUM; i++) begin
      if (irq_type_i[i] == GPIO_IRQ_EDGE) begin
        irq_evt[i] = irq_pol_i[i] ? rise[i] : fall[i];
      end else begin
        irq_evt[i] = (stb[i] == irq_pol_i[i]);
      end
    end
  end

  // Set wins over clear; disabling a pin does not drop its pending bit.
  always_comb begin
    pend_d = (pend_q & ~irq_clr_i) | (irq_evt & irq_en_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pad_i_q   <= '0;
      pad_oen_q <= '1;
      pad_ren_q <= '1;
      pend_q    <= '0;
    end else begin
      pad_i_q   <= pad_i_d;
      pad_oen_q <= pad_oen_d;
      pad_ren_q <= pad_ren_d;
      pend_q    <= pend_d;
    end
  end

  assign pad_i_o    = pad_i_q;
  assign pad_oen_o  = pad_oen_q;
  assign pad_ren_o  = pad_ren_q;
  assign in_o       = stb;
  assign irq_pend_o = pend_q;
  assign irq_o      = |pend_q;

endmodule : gpio_pad_ctrl

// File: tb/tb_gpio_pad_ctrl.sv
module tb_gpio_pad_ctrl;

  localparam int N  = 8;
  localparam int DW = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]  dir, out, pull_en, irq_en, irq_type, irq_pol, irq_clr, pad_c;
  logic [DW-1:0] deb_val;
  logic [N-1:0]  pad_i, pad_oen, pad_ren, in_v, irq_pend;
  logic          irq;

  gpio_pad_ctrl #(.GPIO_NUM(N), .DEB_WIDTH(DW)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .dir_i      (dir),
    .out_i      (out),
    .pull_en_i  (pull_en),
    .deb_val_i  (deb_val),
    .irq_en_i   (irq_en),
    .irq_type_i (irq_type),
    .irq_pol_i  (irq_pol),
    .irq_clr_i  (irq_clr),
    .pad_i_o    (pad_i),
    .pad_oen_o  (pad_oen),
    .pad_ren_o  (pad_ren),
    .pad_c_i    (pad_c),
    .in_o       (in_v),
    .irq_pend_o (irq_pend),
    .irq_o      (irq)
  );

  int checks   = 0;
  int failures = 0;

  // scoreboard check
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // driver: advance n rising edges, land 1 time unit after the last one
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    dir = '0; out = '0; pull_en = '0; deb_val = '0;
    irq_en = '0; irq_type = '0; irq_pol = '0; irq_clr = '0; pad_c = '0;
    tick(2);
    check_eq("rst_oen",  pad_oen,  8'hFF);
    check_eq("rst_ren",  pad_ren,  8'hFF);
    check_eq("rst_pad_i", pad_i,   8'h00);
    check_eq("rst_in",   in_v,     8'h00);
    check_eq("rst_pend", irq_pend, 8'h00);
    check_eq("rst_irq",  irq,      1'b0);
    rst_n = 1'b1;
    tick(1);

    // output path, one cycle
    dir = 8'h0F; out = 8'h05; pull_en = 8'h3C;
    tick(1);
    check_eq("out_oen",   pad_oen, 8'hF0);
    check_eq("out_pad_i", pad_i,   8'h05);
    check_eq("out_ren",   pad_ren, 8'hC3);

    // bypass latency: 3 edges
    deb_val = 8'd0;
    pad_c[0] = 1'b1;
    tick(2);
    check_eq("byp_edge2", in_v[0], 1'b0);
    tick(1);
    check_eq("byp_edge3", in_v[0], 1'b1);
    pad_c[0] = 1'b0;
    tick(5);
    check_eq("byp_back0", in_v[0], 1'b0);

    // debounce N=4: 4-cycle glitch rejected
    deb_val = 8'd4;
    pad_c[1] = 1'b1;
    tick(4);
    pad_c[1] = 1'b0;
    tick(10);
    check_eq("deb_glitch", in_v[1], 1'b0);
    // 5-cycle pulse accepted at edge 7
    pad_c[1] = 1'b1;
    tick(5);
    pad_c[1] = 1'b0;
    tick(1);
    check_eq("deb_edge6", in_v[1], 1'b0);
    tick(1);
    check_eq("deb_edge7", in_v[1], 1'b1);
    tick(12);
    check_eq("deb_settle", in_v[1], 1'b0);

    // edge irq, pin 2 rising, N=2 -> pend at edge 6
    deb_val = 8'd2;
    irq_en[2] = 1'b1; irq_type[2] = 1'b1; irq_pol[2] = 1'b1;
    pad_c[2] = 1'b1;
    tick(5);
    check_eq("edge_pre", irq_pend, 8'h00);
    tick(1);
    check_eq("edge_pend", irq_pend, 8'h04);
    check_eq("edge_irq",  irq,      1'b1);
    irq_clr[2] = 1'b1;
    tick(1);
    irq_clr = '0;
    check_eq("edge_clr_pend", irq_pend, 8'h00);
    check_eq("edge_clr_irq",  irq,      1'b0);
    pad_c[2] = 1'b0;
    tick(10);
    check_eq("edge_fall_none", irq_pend, 8'h00);
    check_eq("edge_fall_in",   in_v[2],  1'b0);

    // level irq, pin 3 high, N=2 -> pend at edge 6
    irq_en[3] = 1'b1; irq_type[3] = 1'b0; irq_pol[3] = 1'b1;
    pad_c[3] = 1'b1;
    tick(5);
    check_eq("lvl_pre", irq_pend, 8'h00);
    tick(1);
    check_eq("lvl_pend", irq_pend, 8'h08);
    irq_clr[3] = 1'b1;
    tick(1);
    irq_clr = '0;
    check_eq("lvl_clr_held", irq_pend, 8'h08);
    check_eq("lvl_clr_irq",  irq,      1'b1);
    irq_en[3] = 1'b0;
    tick(2);
    check_eq("lvl_en_off_keep", irq_pend, 8'h08);
    irq_clr[3] = 1'b1;
    tick(1);
    irq_clr = '0;
    check_eq("lvl_clr_disabled", irq_pend, 8'h00);
    pad_c[3] = 1'b0;
    tick(10);

    // async reset mid-debounce, N=10
    deb_val = 8'd10;
    irq_en[5] = 1'b1; irq_type[5] = 1'b0; irq_pol[5] = 1'b0;  // level low, stb5=0
    tick(1);
    check_eq("ar_pend_before", irq_pend, 8'h20);
    pad_c[4] = 1'b1;
    tick(7);                        // cnt = 5 on pin 4
    check_eq("ar_in_before", in_v[4], 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("ar_oen",   pad_oen,  8'hFF);
    check_eq("ar_ren",   pad_ren,  8'hFF);
    check_eq("ar_pad_i", pad_i,    8'h00);
    check_eq("ar_pend",  irq_pend, 8'h00);
    check_eq("ar_irq",   irq,      1'b0);
    irq_en = '0;
    tick(1);
    rst_n = 1'b1;
    tick(12);
    check_eq("ar_edge12", in_v[4], 1'b0);
    tick(1);
    check_eq("ar_edge13", in_v[4], 1'b1);
    check_eq("ar_no_irq", irq_pend, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_gpio_pad_ctrl
